// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter register and next-PC sequencer
//
// Holds the fetch PC and picks the next one on every accepted fetch.
// It adds a one-cycle boot bubble after reset and a fetch handshake with
// stall. A misaligned target is redirected to TRAP_VECTOR with a one-bubble
// trap cycle. It also keeps a wrapping count of accepted fetches.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   PCPlus4     sequential next PC, used as supplied
//   PCTarget    branch/jal target
//   ALUResult   jalr target, bit 0 cleared before use
//   PCSrc       00 seq, 01 PCTarget, 10 ALUResult&~1, 11 seq
//   Stall       hazard hold, blocks acceptance
//   IMemReady   instruction memory accepts the fetch at PC
//   PC          current fetch address
//   PCValid     PC is a valid fetch request
//   Trap        one-cycle pulse on misaligned-target redirect
//   TrapPC      offending target captured at the last trap
//   InstrCount  accepted fetches, wraps

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    input  logic [1:0]  PCSrc,
    input  logic        Stall,
    input  logic        IMemReady,
    output logic [31:0] PC,
    output logic        PCValid,
    output logic        Trap,
    output logic [31:0] TrapPC,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    logic        accept;
    logic [31:0] next_pc;

    // PCValid is only ever high in RUN, so it doubles as the "in RUN" qualifier.
    assign accept = PCValid & IMemReady & ~Stall;

    always_comb begin
        next_pc = PCPlus4;
        case (PCSrc)
            2'b01:   next_pc = PCTarget;
            2'b10:   next_pc = {ALUResult[31:1], 1'b0};
            default: next_pc = PCPlus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            PC         <= RESET_VECTOR;
            PCValid    <= 1'b0;
            Trap       <= 1'b0;
            TrapPC     <= 32'h0;
            InstrCount <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    PCValid <= 1'b1;
                    Trap    <= 1'b0;
                end
                RUN: begin
                    Trap <= 1'b0;
                    if (accept) begin
                        InstrCount <= InstrCount + 32'd1;
                        if (next_pc[1:0] == 2'b00) begin
                            PC <= next_pc;
                        end else begin
                            // Misaligned target: fetch from the trap vector
                            // after a single bubble and remember the culprit.
                            PC      <= TRAP_VECTOR;
                            TrapPC  <= next_pc;
                            Trap    <= 1'b1;
                            PCValid <= 1'b0;
                            state   <= TRAP;
                        end
                    end
                end
                TRAP: begin
                    Trap    <= 1'b0;
                    PCValid <= 1'b1;
                    state   <= RUN;
                end
                default: begin
                    state   <= BOOT;
                    PCValid <= 1'b0;
                    Trap    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCPlus4;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic [1:0]  PCSrc;
    logic        Stall;
    logic        IMemReady;
    logic [31:0] PC;
    logic        PCValid;
    logic        Trap;
    logic [31:0] TrapPC;
    logic [31:0] InstrCount;

    logic        use_ovr;
    logic [31:0] ovr_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the PC_Plus_4 adder, with an override to show that the
    // sequencer uses PCPlus4 exactly as supplied.
    assign PCPlus4 = use_ovr ? ovr_val : PC + 32'd4;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .PCPlus4    (PCPlus4),
        .PCTarget   (PCTarget),
        .ALUResult  (ALUResult),
        .PCSrc      (PCSrc),
        .Stall      (Stall),
        .IMemReady  (IMemReady),
        .PC         (PC),
        .PCValid    (PCValid),
        .Trap       (Trap),
        .TrapPC     (TrapPC),
        .InstrCount (InstrCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] pc, input logic vld,
                              input logic trp, input logic [31:0] tpc, input logic [31:0] cnt);
        check({tag, ".pc"},    PC,               pc);
        check({tag, ".valid"}, {31'h0, PCValid}, {31'h0, vld});
        check({tag, ".trap"},  {31'h0, Trap},    {31'h0, trp});
        check({tag, ".trappc"}, TrapPC,          tpc);
        check({tag, ".count"}, InstrCount,       cnt);
    endtask

    initial begin
        reset     = 1'b1;
        PCTarget  = 32'h0;
        ALUResult = 32'h0;
        PCSrc     = 2'b00;
        Stall     = 1'b0;
        IMemReady = 1'b1;
        use_ovr   = 1'b0;
        ovr_val   = 32'h0;

        repeat (3) step();
        expect_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // BOOT bubble: one cycle with PCValid low, no accept despite IMemReady.
        reset = 1'b0;
        #2;
        expect_all("boot", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        expect_all("run0", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);

        step(); expect_all("seq4", 32'h4, 1'b1, 1'b0, 32'h0, 32'd1);
        step(); expect_all("seq8", 32'h8, 1'b1, 1'b0, 32'h0, 32'd2);
        step(); expect_all("seqC", 32'hC, 1'b1, 1'b0, 32'h0, 32'd3);

        PCSrc = 2'b01; PCTarget = 32'h40;
        step(); expect_all("br40", 32'h40, 1'b1, 1'b0, 32'h0, 32'd4);

        // Stall beats IMemReady; selects changed meanwhile must be ignored.
        Stall = 1'b1; PCTarget = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step(); expect_all("stall", 32'h40, 1'b1, 1'b0, 32'h0, 32'd4);
        end
        Stall = 1'b0; IMemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); expect_all("notready", 32'h40, 1'b1, 1'b0, 32'h0, 32'd4);
        end
        IMemReady = 1'b1;

        // jalr to 0x123 -> masked 0x122, misaligned -> trap.
        PCSrc = 2'b10; ALUResult = 32'h0000_0123;
        step(); expect_all("trap", 32'h100, 1'b0, 1'b1, 32'h122, 32'd5);
        PCSrc = 2'b00;
        step(); expect_all("posttrap", 32'h100, 1'b1, 1'b0, 32'h122, 32'd5);

        PCSrc = 2'b10; ALUResult = 32'h81;
        step(); expect_all("jalr80", 32'h80, 1'b1, 1'b0, 32'h122, 32'd6);

        PCSrc = 2'b01; PCTarget = 32'hFFFF_FFFC;
        step(); expect_all("brtop", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h122, 32'd7);
        PCSrc = 2'b00;
        step(); expect_all("wrap", 32'h0, 1'b1, 1'b0, 32'h122, 32'd8);

        PCSrc = 2'b11; PCTarget = 32'h40; ALUResult = 32'h81;
        step(); expect_all("src11", 32'h4, 1'b1, 1'b0, 32'h122, 32'd9);

        PCSrc = 2'b00; use_ovr = 1'b1; ovr_val = 32'h200;
        step(); expect_all("ovr", 32'h200, 1'b1, 1'b0, 32'h122, 32'd10);
        use_ovr = 1'b0;

        PCSrc = 2'b01; PCTarget = 32'h202;
        step(); expect_all("trap2", 32'h100, 1'b0, 1'b1, 32'h202, 32'd11);

        // Reset during the TRAP cycle cancels everything.
        reset = 1'b1; PCSrc = 2'b00;
        step(); expect_all("rsttrap", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #2;
        expect_all("boot2", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); expect_all("run2", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(); expect_all("seq2", 32'h4, 1'b1, 1'b0, 32'h0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
